// File: rtl/wnd_sched_pkg.sv
// Shared types and helpers for the sliding-window retransmit scheduler.
package wnd_sched_pkg;

  // Widest bitmap the popcount helper accepts; narrower bitmaps are zero-extended.
  localparam int MAX_W = 256;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_state_e;

  // Ceiling log2, usable in parameter defaults.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Number of set bits in a (zero-extended) bitmap.
  function automatic int unsigned popcount_f(input logic [MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_W; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ff_wnd.sv
// Circular find-first: returns the first bit equal to select_set_in at or after
// start_in, wrapping past the top of the vector. Purely combinational; the
// search is split into BLOCK_WIDTH-bit blocks (block-any, then bit within block).
module ff_wnd #(
  parameter int VECT_WIDTH     = 64,
  parameter int VECT_IND_WIDTH = 6,
  parameter int BLOCK_WIDTH    = 2
) (
  input  logic [VECT_WIDTH-1:0]     vect_in,
  input  logic                      select_set_in,
  input  logic [VECT_IND_WIDTH-1:0] start_in,
  output logic                      val_out,
  output logic [VECT_IND_WIDTH-1:0] ind_out
);

  localparam int NUM_BLK = VECT_WIDTH / BLOCK_WIDTH;

  logic [VECT_WIDTH-1:0]                  w_sel;
  logic [VECT_WIDTH-1:0]                  w_rot;
  logic [NUM_BLK-1:0][BLOCK_WIDTH-1:0]    w_rot_blk;
  logic [NUM_BLK-1:0]                     w_blk_any;
  int                                     w_blk_sel;
  int                                     w_bit_sel;

  // Searching for clear bits is the same as searching for set bits of the inverse.
  assign w_sel = select_set_in ? vect_in : ~vect_in;

  // Rotate so that start_in lands at position 0; index arithmetic wraps naturally.
  genvar gi;
  generate
    for (gi = 0; gi < VECT_WIDTH; gi++) begin : g_rot
      assign w_rot[gi] = w_sel[VECT_IND_WIDTH'(gi) + start_in];
    end
  endgenerate

  assign w_rot_blk = w_rot;

  generate
    for (gi = 0; gi < NUM_BLK; gi++) begin : g_blk
      assign w_blk_any[gi] = |w_rot_blk[gi];
    end
  endgenerate

  // Lowest non-empty block, then lowest set bit inside it.
  always_comb begin
    w_blk_sel = 0;
    w_bit_sel = 0;
    for (int b = NUM_BLK - 1; b >= 0; b--) begin
      if (w_blk_any[b]) w_blk_sel = b;
    end
    for (int j = BLOCK_WIDTH - 1; j >= 0; j--) begin
      if (w_rot_blk[w_blk_sel][j]) w_bit_sel = j;
    end
  end

  assign val_out = |w_blk_any;
  assign ind_out = start_in + VECT_IND_WIDTH'(w_blk_sel * BLOCK_WIDTH + w_bit_sel);

endmodule

// File: rtl/wnd_sched.sv
// Retransmit/transmit scheduler: keeps a pending-slot bitmap and a window head,
// and issues the first pending slot at or after the head on a valid/ready port.
module wnd_sched
  import wnd_sched_pkg::*;
#(
  parameter int VECT_WIDTH     = 64,
  parameter int VECT_IND_WIDTH = clog2_f(VECT_WIDTH),
  parameter int BLOCK_WIDTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_in,
  input  logic                      mark_val_in,
  input  logic [VECT_IND_WIDTH-1:0] mark_ind_in,
  input  logic                      head_val_in,
  input  logic [VECT_IND_WIDTH-1:0] head_in,
  output logic                      out_val,
  output logic [VECT_IND_WIDTH-1:0] out_ind,
  input  logic                      out_rdy,
  output logic [VECT_IND_WIDTH-1:0] head_out,
  output logic [VECT_IND_WIDTH:0]   pend_cnt_out,
  output logic                      empty_out
);

  logic [VECT_WIDTH-1:0]                     r_bitmap;
  logic [VECT_IND_WIDTH-1:0]                 r_head;
  logic [VECT_IND_WIDTH:0]                   r_pend_cnt;
  logic                                      r_empty;
  out_state_e                                r_state;
  logic [VECT_IND_WIDTH-1:0]                 r_out_ind;

  logic                                      w_wnd_val;
  logic [VECT_IND_WIDTH-1:0]                 w_wnd_ind;
  logic                                      w_load;
  logic [VECT_IND_WIDTH-1:0]                 w_adv;
  logic [VECT_WIDTH-1:0][VECT_IND_WIDTH-1:0] w_dist;
  logic [VECT_WIDTH-1:0]                     w_clr;
  logic [VECT_WIDTH-1:0]                     w_mark_hit;
  logic [VECT_WIDTH-1:0]                     w_load_hit;
  logic [VECT_WIDTH-1:0]                     w_bitmap_next;
  logic [VECT_IND_WIDTH:0]                   w_pend_cnt_next;

  // Scan the registered bitmap from the registered head.
  ff_wnd #(
    .VECT_WIDTH    (VECT_WIDTH),
    .VECT_IND_WIDTH(VECT_IND_WIDTH),
    .BLOCK_WIDTH   (BLOCK_WIDTH)
  ) u_ff_wnd (
    .vect_in      (r_bitmap),
    .select_set_in(1'b1),
    .start_in     (r_head),
    .val_out      (w_wnd_val),
    .ind_out      (w_wnd_ind)
  );

  // A new index is taken when the output register is free or being drained.
  assign w_load = en_in & w_wnd_val & ((r_state == ST_EMPTY) | out_rdy);

  // Distance the head moves; slots within that distance behind the new head drop out.
  assign w_adv = head_in - r_head;

  genvar gi;
  generate
    for (gi = 0; gi < VECT_WIDTH; gi++) begin : g_bit
      assign w_dist[gi]     = VECT_IND_WIDTH'(gi) - r_head;
      assign w_clr[gi]      = head_val_in & (w_dist[gi] < w_adv);
      assign w_mark_hit[gi] = mark_val_in & (mark_ind_in == VECT_IND_WIDTH'(gi));
      assign w_load_hit[gi] = w_load & (w_wnd_ind == VECT_IND_WIDTH'(gi));
      // Head clear beats mark, mark beats load, so a re-marked loaded slot stays pending.
      assign w_bitmap_next[gi] = w_clr[gi]      ? 1'b0 :
                                 w_mark_hit[gi] ? 1'b1 :
                                 w_load_hit[gi] ? 1'b0 : r_bitmap[gi];
    end
  endgenerate

  assign w_pend_cnt_next = (VECT_IND_WIDTH + 1)'(popcount_f(MAX_W'(w_bitmap_next)));

  // Bitmap, head and the status counters derived from the next-state bitmap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bitmap   <= '0;
      r_head     <= '0;
      r_pend_cnt <= '0;
      r_empty    <= 1'b1;
    end else begin
      r_bitmap   <= w_bitmap_next;
      r_pend_cnt <= w_pend_cnt_next;
      r_empty    <= (w_bitmap_next == '0);
      if (head_val_in) r_head <= head_in;
    end
  end

  // Output register FSM: a held index stays put until the consumer accepts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_out_ind <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_load) begin
            r_out_ind <= w_wnd_ind;
            r_state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_load) begin
            r_out_ind <= w_wnd_ind;
          end else if (out_rdy) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign out_val      = (r_state == ST_HOLD);
  assign out_ind      = r_out_ind;
  assign head_out     = r_head;
  assign pend_cnt_out = r_pend_cnt;
  assign empty_out    = r_empty;

endmodule

// File: tb/tb_wnd_sched.sv
// Directed bench for wnd_sched with an 8-slot window.
module tb_wnd_sched;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk;
  logic          rst_n;
  logic          en_in;
  logic          mark_val_in;
  logic [IW-1:0] mark_ind_in;
  logic          head_val_in;
  logic [IW-1:0] head_in;
  logic          out_val;
  logic [IW-1:0] out_ind;
  logic          out_rdy;
  logic [IW-1:0] head_out;
  logic [IW:0]   pend_cnt_out;
  logic          empty_out;

  int errors = 0;
  int checks = 0;

  wnd_sched #(
    .VECT_WIDTH    (W),
    .VECT_IND_WIDTH(IW),
    .BLOCK_WIDTH   (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_in       (en_in),
    .mark_val_in (mark_val_in),
    .mark_ind_in (mark_ind_in),
    .head_val_in (head_val_in),
    .head_in     (head_in),
    .out_val     (out_val),
    .out_ind     (out_ind),
    .out_rdy     (out_rdy),
    .head_out    (head_out),
    .pend_cnt_out(pend_cnt_out),
    .empty_out   (empty_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs changed 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en_in = 1'b0; mark_val_in = 1'b0; mark_ind_in = '0;
    head_val_in = 1'b0; head_in = '0; out_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic mark_slot(input int idx);
    mark_val_in = 1'b1; mark_ind_in = IW'(idx);
    tick();
    mark_val_in = 1'b0;
  endtask

  task automatic set_head(input int h);
    head_val_in = 1'b1; head_in = IW'(h);
    tick();
    head_val_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_in = 1'b0; mark_val_in = 1'b0; mark_ind_in = '0;
    head_val_in = 1'b0; head_in = '0; out_rdy = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %0d want 0", out_val); end
    checks++; if (out_ind !== 3'd0) begin errors++; $display("FAIL reset_ind: got %0d want 0", out_ind); end
    checks++; if (head_out !== 3'd0) begin errors++; $display("FAIL reset_head: got %0d want 0", head_out); end
    checks++; if (pend_cnt_out !== 4'd0) begin errors++; $display("FAIL reset_pend: got %0d want 0", pend_cnt_out); end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0d want 1", empty_out); end
    $display("test_reset done");
  endtask

  task automatic test_single_mark();
    do_reset();
    en_in = 1'b1; out_rdy = 1'b1;
    mark_slot(5);
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL single_early_val: got %0d want 0", out_val); end
    checks++; if (pend_cnt_out !== 4'd1) begin errors++; $display("FAIL single_pend1: got %0d want 1", pend_cnt_out); end
    checks++; if (empty_out !== 1'b0) begin errors++; $display("FAIL single_empty0: got %0d want 0", empty_out); end
    tick();
    checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL single_val: got %0d want 1", out_val); end
    checks++; if (out_ind !== 3'd5) begin errors++; $display("FAIL single_ind: got %0d want 5", out_ind); end
    checks++; if (pend_cnt_out !== 4'd0) begin errors++; $display("FAIL single_pend0: got %0d want 0", pend_cnt_out); end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL single_empty1: got %0d want 1", empty_out); end
    tick();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL single_drain: got %0d want 0", out_val); end
    $display("test_single_mark done");
  endtask

  task automatic test_wrap_order();
    int exp_ind [3] = '{7, 1, 3};
    do_reset();
    set_head(6);
    checks++; if (head_out !== 3'd6) begin errors++; $display("FAIL wrap_head: got %0d want 6", head_out); end
    mark_slot(1); mark_slot(3); mark_slot(7);
    checks++; if (pend_cnt_out !== 4'd3) begin errors++; $display("FAIL wrap_pend: got %0d want 3", pend_cnt_out); end
    en_in = 1'b1; out_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_val !== 1'b1 || out_ind !== IW'(exp_ind[k])) begin
        errors++; $display("FAIL wrap_seq%0d: got val=%0d ind=%0d want val=1 ind=%0d", k, out_val, out_ind, exp_ind[k]);
      end
    end
    tick();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL wrap_drain: got %0d want 0", out_val); end
    $display("test_wrap_order done");
  endtask

  task automatic test_backpressure();
    do_reset();
    mark_slot(2); mark_slot(4);
    en_in = 1'b1; out_rdy = 1'b0;
    tick();
    checks++; if (out_val !== 1'b1 || out_ind !== 3'd2) begin errors++; $display("FAIL bp_first: got val=%0d ind=%0d want 1/2", out_val, out_ind); end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_val !== 1'b1 || out_ind !== 3'd2) begin
        errors++; $display("FAIL bp_hold%0d: got val=%0d ind=%0d want 1/2", k, out_val, out_ind);
      end
    end
    checks++; if (pend_cnt_out !== 4'd1) begin errors++; $display("FAIL bp_pend: got %0d want 1", pend_cnt_out); end
    out_rdy = 1'b1;
    tick();
    checks++; if (out_val !== 1'b1 || out_ind !== 3'd4) begin errors++; $display("FAIL bp_second: got val=%0d ind=%0d want 1/4", out_val, out_ind); end
    tick();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL bp_nodup: got %0d want 0", out_val); end
    checks++; if (pend_cnt_out !== 4'd0) begin errors++; $display("FAIL bp_pend0: got %0d want 0", pend_cnt_out); end
    $display("test_backpressure done");
  endtask

  task automatic test_head_clear();
    do_reset();
    mark_slot(1); mark_slot(2); mark_slot(5);
    set_head(3);
    checks++; if (pend_cnt_out !== 4'd1) begin errors++; $display("FAIL hc_pend: got %0d want 1", pend_cnt_out); end
    checks++; if (head_out !== 3'd3) begin errors++; $display("FAIL hc_head: got %0d want 3", head_out); end
    en_in = 1'b1; out_rdy = 1'b1;
    tick();
    checks++; if (out_val !== 1'b1 || out_ind !== 3'd5) begin errors++; $display("FAIL hc_issue: got val=%0d ind=%0d want 1/5", out_val, out_ind); end
    tick();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL hc_drain: got %0d want 0", out_val); end
    en_in = 1'b0;
    set_head(6);
    mark_slot(6); mark_slot(7); mark_slot(0); mark_slot(1); mark_slot(2);
    checks++; if (pend_cnt_out !== 4'd5) begin errors++; $display("FAIL hc_pend5: got %0d want 5", pend_cnt_out); end
    set_head(1);
    checks++; if (pend_cnt_out !== 4'd2) begin errors++; $display("FAIL hc_wrap_pend: got %0d want 2", pend_cnt_out); end
    checks++; if (head_out !== 3'd1) begin errors++; $display("FAIL hc_wrap_head: got %0d want 1", head_out); end
    en_in = 1'b1;
    tick();
    checks++; if (out_val !== 1'b1 || out_ind !== 3'd1) begin errors++; $display("FAIL hc_wrap_a: got val=%0d ind=%0d want 1/1", out_val, out_ind); end
    tick();
    checks++; if (out_val !== 1'b1 || out_ind !== 3'd2) begin errors++; $display("FAIL hc_wrap_b: got val=%0d ind=%0d want 1/2", out_val, out_ind); end
    tick();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL hc_wrap_drain: got %0d want 0", out_val); end
    $display("test_head_clear done");
  endtask

  task automatic test_collision();
    do_reset();
    out_rdy = 1'b1;
    mark_slot(4);
    en_in = 1'b1;
    mark_val_in = 1'b1; mark_ind_in = 3'd4;
    tick();
    mark_val_in = 1'b0;
    checks++; if (out_val !== 1'b1 || out_ind !== 3'd4) begin errors++; $display("FAIL col_first: got val=%0d ind=%0d want 1/4", out_val, out_ind); end
    checks++; if (pend_cnt_out !== 4'd1) begin errors++; $display("FAIL col_pend: got %0d want 1", pend_cnt_out); end
    tick();
    checks++; if (out_val !== 1'b1 || out_ind !== 3'd4) begin errors++; $display("FAIL col_again: got val=%0d ind=%0d want 1/4", out_val, out_ind); end
    checks++; if (pend_cnt_out !== 4'd0) begin errors++; $display("FAIL col_pend0: got %0d want 0", pend_cnt_out); end
    tick();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL col_drain: got %0d want 0", out_val); end
    en_in = 1'b0;
    head_val_in = 1'b1; head_in = 3'd3;
    mark_val_in = 1'b1; mark_ind_in = 3'd2;
    tick();
    head_val_in = 1'b0; mark_val_in = 1'b0;
    checks++; if (pend_cnt_out !== 4'd0) begin errors++; $display("FAIL col_clr_pend: got %0d want 0", pend_cnt_out); end
    checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL col_clr_empty: got %0d want 1", empty_out); end
    en_in = 1'b1;
    tick();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL col_clr_val: got %0d want 0", out_val); end
    $display("test_collision done");
  endtask

  task automatic test_reset_enable();
    do_reset();
    set_head(2);
    mark_slot(5); mark_slot(6);
    en_in = 1'b1; out_rdy = 1'b0;
    tick();
    checks++; if (out_val !== 1'b1 || out_ind !== 3'd5) begin errors++; $display("FAIL re_hold: got val=%0d ind=%0d want 1/5", out_val, out_ind); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; en_in = 1'b0;
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL re_val: got %0d want 0", out_val); end
    checks++; if (out_ind !== 3'd0) begin errors++; $display("FAIL re_ind: got %0d want 0", out_ind); end
    checks++; if (pend_cnt_out !== 4'd0) begin errors++; $display("FAIL re_pend: got %0d want 0", pend_cnt_out); end
    checks++; if (head_out !== 3'd0) begin errors++; $display("FAIL re_head: got %0d want 0", head_out); end
    mark_slot(3);
    tick(); tick();
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL en_off_val: got %0d want 0", out_val); end
    checks++; if (pend_cnt_out !== 4'd1) begin errors++; $display("FAIL en_off_pend: got %0d want 1", pend_cnt_out); end
    en_in = 1'b1;
    tick();
    checks++; if (out_val !== 1'b1 || out_ind !== 3'd3) begin errors++; $display("FAIL en_on: got val=%0d ind=%0d want 1/3", out_val, out_ind); end
    $display("test_reset_enable done");
  endtask

  initial begin
    test_reset();
    test_single_mark();
    test_wrap_order();
    test_backpressure();
    test_head_clear();
    test_collision();
    test_reset_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wnd_sched.md
Name: wnd_sched

Overview:
- Retransmit/transmit scheduler for a sliding-window bitmap of VECT_WIDTH slots.
- Holds a registered pending bitmap and a head pointer. Each cycle it uses ff_wnd (select_set_in=1) to find the first pending slot at or after head, wrapping circularly.
- Issues that slot index on a valid/ready output and clears the slot when it is loaded.
- Sits between the loss/timeout detector, which marks slots, and the packet-generation engine, which consumes indices.

Parameters:
- VECT_WIDTH, 64, window size in slots; must be a power of 2.
- VECT_IND_WIDTH, 6, log2(VECT_WIDTH).
- BLOCK_WIDTH, 2, passed through to ff_wnd.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- en_in  in  1  scheduling enable; 0 stops new loads
- mark_val_in  in  1  mark a slot pending
- mark_ind_in  in  VECT_IND_WIDTH  slot to mark
- head_val_in  in  1  window advance
- head_in  in  VECT_IND_WIDTH  new head
- out_val  out  1  index valid
- out_ind  out  VECT_IND_WIDTH  scheduled slot
- out_rdy  in  1  consumer accept
- head_out  out  VECT_IND_WIDTH  current registered head
- pend_cnt_out  out  VECT_IND_WIDTH+1  registered popcount of bitmap
- empty_out  out  1  bitmap==0 (registered)

Behaviour:
- Reset (rst_n=0 at a clk edge): bitmap=0, head=0, out_val=0, out_ind=0, pend_cnt_out=0, empty_out=1.
- Reset applied mid-operation discards any held out_ind with no handshake.
- Output register has two states:
  - EMPTY (out_val=0).
  - HOLD (out_val=1).
- Load condition: load = en_in & wnd_val & (EMPTY | (HOLD & out_rdy)). The ff_wnd scan runs on the registered bitmap and registered head.
- On load, out_ind <= ff_wnd ind and the state stays or becomes HOLD.
- HOLD & out_rdy & !load -> EMPTY.
- out_val/out_ind are stable while out_rdy=0. The held index is never retracted, not even by a head advance or en_in=0.
- Back-to-back: with out_rdy=1 continuously, one index per cycle.
- Head clear: on head_val_in, bit i is cleared iff ((i-head) mod W) < ((head_in-head) mod W). head <= head_in. head_in==head clears nothing. Arithmetic is in VECT_IND_WIDTH bits, wrapping naturally.
- Per-bit next state, in priority order:
  - head clear -> 0
  - else mark -> 1
  - else load of this index -> 0
  - else hold
- A mark on the index being loaded the same cycle leaves it pending, so it is rescheduled.
- Latency:
  - mark at edge t -> bitmap bit set after edge t -> out_val=1 after edge t+1, if EMPTY and en_in=1.
  - head advance affects the scan from the next cycle.
- pend_cnt_out and empty_out are registered from the next-state bitmap, so they are coherent with the bitmap every cycle.
- Wrap: the scan starts at head, covers head..W-1, then 0..head-1. ff_wnd gives this directly.

Decomposition:
- Shared include/package holds slot-index width derivation (clog2 helper) and the popcount function.
- One sub-module: the existing ff_wnd, instantiated once with select_set_in tied 1.
- Head-clear mask generation and popcount stay inline.

Test Plan:
- Single mark: W=8, head=0, out_rdy=1, mark 5 at cycle 1 -> out_val=1, out_ind=5 at cycle 3; pend_cnt 1->0; empty_out=1 afterwards.
- Wrap order: head=6, marks {1,3,7}, out_rdy=1 -> indices 7,1,3 on consecutive cycles.
- Backpressure: marks {2,4}, out_rdy=0 for 5 cycles -> out_ind stays 2; on release -> 2 then 4 accepted; no duplicates.
- Head clear: bitmap {1,2,5}, head 0->3 -> bitmap {5}, pend_cnt=1; a wrapped advance 6->1 clears slots 6,7,0.
- Collisions:
  - mark 4 in the same cycle 4 is loaded -> 4 is issued twice.
  - head clear and mark on slot 2 in the same cycle -> slot 2 stays 0.
- Reset and enable: rst_n=0 while HOLD with out_ind=5 -> next cycle out_val=0, pend_cnt=0, head=0; en_in=0 with pending bits -> no load, out_val stays 0.
